lsu_mem_stage: RTL

- Load/store unit directly downstream of the ALU; consumes the ALU result as the effective byte address.
- Drives a req/gnt/rvalid data-memory port and returns formatted load data to writeback.
- Holds the single-cycle core via `stall` until the access completes.
- Handles byte/half/word sizing, sign/zero extension, misalignment detection and a bus timeout.

---
 rtl/lsu_pkg.sv | 9 +
 rtl/lsu_align.sv | 33 +++
 rtl/lsu_mem_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding and RV32I load/store size codes
package lsu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering, legality check and load extraction
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic        op_write,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic        bad,
  output logic [31:0] ldata
);
  logic [7:0] b;
  logic [15:0] h;
  logic illegal, mis;
  assign b = mem_rdata[{off, 3'b000} +: 8];
  assign h = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign illegal = op_write ? (funct3 != F3_B && funct3 != F3_H && funct3 != F3_W)
                            : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
  assign mis = (funct3[1:0] == 2'b01 && off[0]) || (funct3 == F3_W && off != 2'b00);
  assign bad = illegal | mis;
  // loads always fetch the whole word; stores enable only the lanes they write
  always_comb begin
    be = !op_write ? 4'hF : funct3 == F3_B ? 4'b0001 << off : funct3 == F3_H ? (off[1] ? 4'b1100 : 4'b0011) : 4'hF;
    wdata_lane = funct3 == F3_B ? {4{wdata[7:0]}} : funct3 == F3_H ? {2{wdata[15:0]}} : wdata;
    ldata = funct3 == F3_B  ? {{24{b[7]}}, b} :
            funct3 == F3_BU ? {24'b0, b} :
            funct3 == F3_H  ? {{16{h[15]}}, h} :
            funct3 == F3_HU ? {16'b0, h} : mem_rdata;
  end
endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: stalling load/store unit driving a req/gnt/rvalid memory port
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic              op_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              misalign_err,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  state_t state;
  logic wr_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic [31:0] wd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CW-1:0] cnt;
  logic idle, bad, to;
  logic [31:0] ldata;
  assign idle = state == S_IDLE;
  assign to = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign done = state == S_DONE;
  assign mem_req = state == S_REQ;
  assign mem_we = wr_q;
  assign mem_addr = addr_q;
  assign stall = rst_n & op_valid & (state != S_DONE);
  // in IDLE the live instruction is checked; afterwards the captured copy drives the port
  lsu_align u_align (
    .funct3    (idle ? funct3 : f3_q),
    .off       (idle ? addr[1:0] : off_q),
    .op_write  (idle ? op_write : wr_q),
    .wdata     (idle ? wdata : wd_q),
    .mem_rdata (mem_rdata),
    .be        (mem_be),
    .wdata_lane(mem_wdata),
    .bad       (bad),
    .ldata     (ldata)
  );
  // access sequencer with bus timeout; error flags live only in the DONE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      wr_q <= 1'b0;
      f3_q <= '0;
      off_q <= '0;
      wd_q <= '0;
      addr_q <= '0;
      cnt <= '0;
      rdata <= '0;
      misalign_err <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (op_valid) begin
          wr_q <= op_write;
          f3_q <= funct3;
          off_q <= addr[1:0];
          wd_q <= wdata;
          addr_q <= {addr[ADDR_W-1:2], 2'b00};
          cnt <= '0;
          misalign_err <= bad;
          state <= bad ? S_DONE : S_REQ;
        end
        S_REQ: begin
          cnt <= cnt + 1'b1;
          if (mem_gnt) state <= wr_q ? S_DONE : S_WAIT;
          else if (to) begin
            bus_err <= 1'b1;
            rdata <= '0;
            state <= S_DONE;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_rvalid) begin
            rdata <= ldata;
            state <= S_DONE;
          end else if (to) begin
            bus_err <= 1'b1;
            rdata <= '0;
            state <= S_DONE;
          end
        end
        default: begin
          misalign_err <= 1'b0;
          bus_err <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
